pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of each payload word (PC, ALU result, store value).
REQ-002 Parameter NWORDS, default 3: number of DATA_W payload words carried per stage.
REQ-003 Parameter CTRL_W, default 3: width of the control-enable vector (WB_EN, MEM_R_EN, MEM_W_EN order, LSB = WB_EN).
REQ-004 Parameter DEST_W, default 5: destination register address width.
REQ-005 Parameter SKID, default 1: 1 selects a registered-ready 2-entry skid buffer; 0 selects a single register with combinational ready.
REQ-006 clk  input  1  stage clock; all state changes on rising edge.
REQ-007 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-008 in_valid  input  1  upstream stage holds a valid instruction.
REQ-009 in_ready  output  1  stage accepts in_* this cycle.
REQ-010 in_ctrl  input  CTRL_W  control enables of incoming instruction.
REQ-011 in_data  input  NWORDS*DATA_W  concatenated payload words, word 0 in LSBs.
REQ-012 in_dest  input  DEST_W  incoming destination register.
REQ-013 flush  input  1  kill all held and incoming instructions this cycle.
REQ-014 out_valid  output  1  stage presents a valid instruction.
REQ-015 out_ready  input  1  downstream stage consumes out_* this cycle.
REQ-016 out_ctrl, out_data, out_dest  output  CTRL_W / NWORDS*DATA_W / DEST_W  registered instruction fields.
REQ-017 occupancy  output  2  number of instructions held (0..2).

Function
REQ-018 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready.
REQ-019 Latency: an instruction accepted into an empty stage appears on out_* the following cycle.
REQ-020 SKID=1 states: EMPTY (occ 0), FULL (main reg valid, occ 1), SKID (main + skid reg valid, occ 2).
REQ-021 EMPTY: accept -> FULL.
REQ-022 FULL: accept && !drain -> SKID (incoming word to skid reg); accept && drain -> FULL with new word in main; drain only -> EMPTY; neither -> hold.
REQ-023 SKID: drain -> FULL, skid reg moves to main reg in the same edge; no drain -> hold; no accept possible.
REQ-024 SKID=1: in_ready is a register output equal to (state != SKID); no combinational path from out_ready to in_ready.
REQ-025 SKID=0: in_ready = !out_valid || out_ready combinationally; occupancy never exceeds 1.
REQ-026 Order is strictly preserved; no instruction is duplicated or dropped absent flush.
REQ-027 While out_valid is 1 and out_ready is 0, out_ctrl/out_data/out_dest hold stable.
REQ-028 Whenever out_valid is 0, out_ctrl SHALL be all-zero (bubble carries no write/memory enables); out_data/out_dest are don't-care.
REQ-029 flush at an edge: state -> EMPTY, out_valid 0, out_ctrl 0, occupancy 0; a simultaneous in_valid is discarded; flush has priority over accept and drain.
REQ-030 in_ready during flush cycle keeps its registered value; the discarded word is not counted as accepted.

Reset
REQ-031 rst_n low asynchronously forces state EMPTY, out_valid 0, in_ready 0, occupancy 0, out_ctrl/out_data/out_dest all-zero.
REQ-032 in_ready rises to 1 on the first rising edge after rst_n deasserts; reset asserted mid-transfer discards all held instructions.

Structure
REQ-033 State encoding (EMPTY/FULL/SKID) and default widths belong in the shared pipeline package pipe_pkg.
REQ-034 One sub-module pipe_field_reg (enable-loaded register, width = CTRL_W+NWORDS*DATA_W+DEST_W) instantiated as main and skid registers.

Verification
REQ-035 Reset then in_valid=1, ctrl=3'b001, data word0=0x00000010, dest=5, out_ready=1 -> next cycle out_valid=1, out_ctrl=001, word0=0x10, out_dest=5.
REQ-036 out_ready=0, push A=0x1, B=0x2 -> occupancy 2, in_ready 0, out shows A; out_ready=1 -> A then B on consecutive cycles, in_ready 1 after A drains.
REQ-037 Occupancy 2 plus in_valid=1 with flush=1 -> next cycle out_valid 0, out_ctrl 000, occupancy 0, incoming word never appears.
REQ-038 Continuous in_valid/out_ready=1 for 100 words 0..99 -> outputs 0..99 in order, one per cycle, in_ready never 0.
REQ-039 rst_n dropped asynchronously between edges while FULL -> outputs zero immediately without a clock edge.
REQ-040 SKID=0 build, out_ready toggling every cycle with random in_valid -> in_ready equals !out_valid||out_ready each cycle, no loss or duplication.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage state encoding and default field widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NWORDS = 3;
  localparam int DEF_CTRL_W = 3;
  localparam int DEF_DEST_W = 5;

  function automatic int fld_w(input int ctrl_w, input int nwords, input int data_w, input int dest_w);
    return ctrl_w + nwords * data_w + dest_w;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Stage-side bundle: upstream handshake, downstream handshake, flush and occupancy.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NWORDS = DEF_NWORDS,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DEST_W = DEF_DEST_W
);
  logic                     in_valid;
  logic                     in_ready;
  logic [CTRL_W-1:0]        in_ctrl;
  logic [NWORDS*DATA_W-1:0] in_data;
  logic [DEST_W-1:0]        in_dest;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [CTRL_W-1:0]        out_ctrl;
  logic [NWORDS*DATA_W-1:0] out_data;
  logic [DEST_W-1:0]        out_dest;
  logic [1:0]               occupancy;

  modport slave (
    input  in_valid, in_ctrl, in_data, in_dest, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, out_dest, occupancy
  );

  modport master (
    output in_valid, in_ctrl, in_data, in_dest, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, out_dest, occupancy
  );
endinterface

// File: rtl/pipe_field_reg.sv
// Enable-loaded instruction field register, cleared by reset.
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    o_q <= '0;
    else if (i_en) o_q <= i_d;
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: 2-entry skid buffer with registered ready (SKID=1)
// or a single register with combinational ready (SKID=0).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NWORDS = DEF_NWORDS,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DEST_W = DEF_DEST_W,
  parameter int SKID   = 1
) (
  input logic              clk,
  input logic              rst_n,
  pipe_stage_reg_if.slave  bus
);
  localparam int FW = fld_w(CTRL_W, NWORDS, DATA_W, DEST_W);

  pipe_state_e       r_state, w_state_nxt;
  logic              r_in_rdy, w_in_rdy_nxt;
  logic              w_acc, w_drn, w_valid, w_main_en, w_skid_en;
  logic [FW-1:0]     w_in_fld, w_main_d, w_main_q, w_skid_q;
  logic [CTRL_W-1:0] w_q_ctrl;

  assign w_valid  = (r_state != ST_EMPTY);
  assign w_in_fld = {bus.in_ctrl, bus.in_data, bus.in_dest};
  // r_in_rdy also masks ready during and right after reset in the SKID=0 build
  assign bus.in_ready = (SKID != 0) ? r_in_rdy : (r_in_rdy & (~w_valid | bus.out_ready));
  assign w_acc = bus.in_valid & bus.in_ready & ~bus.flush;
  assign w_drn = w_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_EMPTY;
      r_in_rdy <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_in_rdy <= w_in_rdy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) w_state_nxt = ST_EMPTY;
    else begin
      case (r_state)
        ST_EMPTY: if (w_acc) w_state_nxt = ST_FULL;
        ST_FULL: begin
          if (w_acc && !w_drn)      w_state_nxt = (SKID != 0) ? ST_SKID : ST_FULL;
          else if (!w_acc && w_drn) w_state_nxt = ST_EMPTY;
        end
        ST_SKID:  if (w_drn) w_state_nxt = ST_FULL;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_main_en    = 1'b0;
    w_skid_en    = 1'b0;
    w_main_d     = w_in_fld;
    w_in_rdy_nxt = (SKID != 0) ? (w_state_nxt != ST_SKID) : 1'b1;
    if (!bus.flush) begin
      case (r_state)
        ST_EMPTY: w_main_en = w_acc;
        ST_FULL: begin
          w_main_en = w_acc & w_drn;
          w_skid_en = w_acc & ~w_drn;
        end
        ST_SKID: begin
          w_main_en = w_drn;
          w_main_d  = w_skid_q;
        end
        default: ;
      endcase
    end
  end

  pipe_field_reg #(.W(FW)) u_main (
    .clk(clk), .rst_n(rst_n), .i_en(w_main_en), .i_d(w_main_d), .o_q(w_main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_field_reg #(.W(FW)) u_skid (
        .clk(clk), .rst_n(rst_n), .i_en(w_skid_en), .i_d(w_in_fld), .o_q(w_skid_q)
      );
    end else begin : g_noskid
      assign w_skid_q = '0;
    end
  endgenerate

  // A bubble must never carry write/memory enables downstream
  assign {w_q_ctrl, bus.out_data, bus.out_dest} = w_main_q;
  assign bus.out_ctrl  = w_valid ? w_q_ctrl : '0;
  assign bus.out_valid = w_valid;
  assign bus.occupancy = r_state;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid build (b1) and combinational-ready build (b0).
module tb_pipe_stage_reg;
  localparam int CW = 3, DW = 32, NW = 3, DS = 5;
  localparam int FW = CW + NW * DW + DS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_stage_reg_if b1 ();
  pipe_stage_reg_if b0 ();

  pipe_stage_reg #(.SKID(1)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(b1));
  pipe_stage_reg #(.SKID(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  logic [FW-1:0] q1[$];
  logic [FW-1:0] q0[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic sb_check(input logic [FW-1:0] got, input bit which);
    logic [FW-1:0] exp;
    n_cmp++;
    if ((which ? q1.size() : q0.size()) == 0) begin
      n_bad++;
      $display("FAIL sb%0d_unexpected got=%h required=none", which, got);
    end else begin
      exp = which ? q1.pop_front() : q0.pop_front();
      if (got !== exp) begin
        n_bad++;
        $display("FAIL sb%0d_order got=%h required=%h", which, got, exp);
      end
    end
  endtask

  // Samples both stages mid-cycle, then advances to just after the next edge
  task automatic step();
    @(negedge clk);
    if (rst_n) begin
      if (b1.flush) q1.delete();
      else begin
        if (b1.out_valid && b1.out_ready) sb_check({b1.out_ctrl, b1.out_data, b1.out_dest}, 1'b1);
        if (b1.in_valid && b1.in_ready) q1.push_back({b1.in_ctrl, b1.in_data, b1.in_dest});
      end
      if (b0.out_valid && b0.out_ready) sb_check({b0.out_ctrl, b0.out_data, b0.out_dest}, 1'b0);
      if (b0.in_valid && b0.in_ready) q0.push_back({b0.in_ctrl, b0.in_data, b0.in_dest});
      if (!b1.out_valid) begin
        n_cmp++;
        if (b1.out_ctrl !== 3'b000) begin
          n_bad++; $display("FAIL bubble_ctrl1 got=%b required=000", b1.out_ctrl);
        end
      end
      if (!b0.out_valid) begin
        n_cmp++;
        if (b0.out_ctrl !== 3'b000) begin
          n_bad++; $display("FAIL bubble_ctrl0 got=%b required=000", b0.out_ctrl);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] w0, input logic [DS-1:0] d);
    b1.in_valid = v;
    b1.in_ctrl  = c;
    b1.in_data  = {64'h0, w0};
    b1.in_dest  = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive1(1'b0, '0, '0, '0);
    b1.flush = 0; b1.out_ready = 1;
    b0.in_valid = 0; b0.in_ctrl = '0; b0.in_data = '0; b0.in_dest = '0;
    b0.flush = 0; b0.out_ready = 1;
    #2;
    n_cmp++;
    if ({b1.out_valid, b1.in_ready, b1.occupancy, b1.out_ctrl, b1.out_data, b1.out_dest} !== '0) begin
      n_bad++; $display("FAIL reset_state1 got v=%b r=%b occ=%0d c=%b d=%h dst=%0d required all-zero",
        b1.out_valid, b1.in_ready, b1.occupancy, b1.out_ctrl, b1.out_data, b1.out_dest);
    end
    n_cmp++;
    if ({b0.out_valid, b0.in_ready, b0.occupancy} !== 4'b0) begin
      n_bad++; $display("FAIL reset_state0 got v=%b r=%b occ=%0d required 0", b0.out_valid, b0.in_ready, b0.occupancy);
    end
    step(); step();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (b1.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL ready_before_edge got=%b required=0", b1.in_ready);
    end
    step();
    n_cmp++;
    if (b1.in_ready !== 1'b1 || b0.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_edge got=%b/%b required=1/1", b1.in_ready, b0.in_ready);
    end
  endtask

  task automatic test_basic();
    b1.out_ready = 1;
    drive1(1'b1, 3'b001, 32'h10, 5'd5);
    step();
    drive1(1'b0, '0, '0, '0);
    n_cmp++;
    if (b1.out_valid !== 1'b1 || b1.out_ctrl !== 3'b001 || b1.out_data[31:0] !== 32'h10 || b1.out_dest !== 5'd5) begin
      n_bad++; $display("FAIL basic_latency got v=%b c=%b w0=%h dst=%0d required v=1 c=001 w0=10 dst=5",
        b1.out_valid, b1.out_ctrl, b1.out_data[31:0], b1.out_dest);
    end
    step();
  endtask

  task automatic test_skid();
    b1.out_ready = 0;
    drive1(1'b1, 3'b011, 32'h1, 5'd1); step();
    drive1(1'b1, 3'b101, 32'h2, 5'd2); step();
    drive1(1'b0, '0, '0, '0);
    n_cmp++;
    if (b1.occupancy !== 2'd2 || b1.in_ready !== 1'b0 || b1.out_data[31:0] !== 32'h1) begin
      n_bad++; $display("FAIL skid_full got occ=%0d r=%b w0=%h required occ=2 r=0 w0=1", b1.occupancy, b1.in_ready, b1.out_data[31:0]);
    end
    step();
    n_cmp++;
    if (b1.out_data[31:0] !== 32'h1 || b1.out_ctrl !== 3'b011 || b1.out_dest !== 5'd1) begin
      n_bad++; $display("FAIL skid_hold got w0=%h c=%b dst=%0d required w0=1 c=011 dst=1", b1.out_data[31:0], b1.out_ctrl, b1.out_dest);
    end
    b1.out_ready = 1;
    step();
    n_cmp++;
    if (b1.in_ready !== 1'b1 || b1.out_data[31:0] !== 32'h2 || b1.occupancy !== 2'd1) begin
      n_bad++; $display("FAIL skid_drain got r=%b w0=%h occ=%0d required r=1 w0=2 occ=1", b1.in_ready, b1.out_data[31:0], b1.occupancy);
    end
    step();
    n_cmp++;
    if (b1.occupancy !== 2'd0 || b1.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL skid_empty got occ=%0d v=%b required occ=0 v=0", b1.occupancy, b1.out_valid);
    end
  endtask

  task automatic test_flush();
    b1.out_ready = 0;
    drive1(1'b1, 3'b111, 32'hC, 5'd3); step();
    drive1(1'b1, 3'b111, 32'hD, 5'd4); step();
    drive1(1'b1, 3'b111, 32'hE, 5'd6);
    b1.flush = 1;
    step();
    b1.flush = 0;
    drive1(1'b0, '0, '0, '0);
    n_cmp++;
    if (b1.out_valid !== 1'b0 || b1.out_ctrl !== 3'b000 || b1.occupancy !== 2'd0) begin
      n_bad++; $display("FAIL flush_skid got v=%b c=%b occ=%0d required 0/000/0", b1.out_valid, b1.out_ctrl, b1.occupancy);
    end
    b1.out_ready = 1;
    step(); step(); step();
    b1.out_ready = 0;
    drive1(1'b1, 3'b001, 32'hF, 5'd7); step();
    drive1(1'b1, 3'b001, 32'h9, 5'd8);
    b1.flush = 1;
    step();
    b1.flush = 0;
    drive1(1'b0, '0, '0, '0);
    n_cmp++;
    if (b1.out_valid !== 1'b0 || b1.occupancy !== 2'd0 || b1.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_full got v=%b occ=%0d r=%b required 0/0/1", b1.out_valid, b1.occupancy, b1.in_ready);
    end
    b1.out_ready = 1;
    step(); step();
  endtask

  task automatic test_back_to_back();
    b1.out_ready = 1;
    for (int i = 0; i < 100; i++) begin
      drive1(1'b1, 3'(i), 32'(i), 5'(i));
      n_cmp++;
      if (b1.in_ready !== 1'b1) begin
        n_bad++; $display("FAIL b2b_ready word=%0d got=%b required=1", i, b1.in_ready);
      end
      step();
    end
    drive1(1'b0, '0, '0, '0);
    step(); step();
    n_cmp++;
    if (q1.size() != 0) begin
      n_bad++; $display("FAIL b2b_lost got=%0d pending required=0", q1.size());
    end
  endtask

  task automatic test_async_reset();
    b1.out_ready = 0;
    drive1(1'b1, 3'b111, 32'hABCD, 5'd9); step();
    drive1(1'b0, '0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({b1.out_valid, b1.in_ready, b1.occupancy, b1.out_ctrl, b1.out_data, b1.out_dest} !== '0) begin
      n_bad++; $display("FAIL async_reset got v=%b r=%b occ=%0d c=%b w0=%h dst=%0d required all-zero",
        b1.out_valid, b1.in_ready, b1.occupancy, b1.out_ctrl, b1.out_data[31:0], b1.out_dest);
    end
    q1.delete(); q0.delete();
    step();
    rst_n = 1'b1;
    step();
    b1.out_ready = 1;
  endtask

  task automatic test_skid0();
    logic [CW-1:0] c;
    for (int k = 0; k < 60; k++) begin
      c = 3'($urandom);
      b0.out_ready = k[0];
      b0.in_valid  = 1'($urandom_range(0, 1));
      b0.in_ctrl   = c;
      b0.in_data   = {64'h0, 32'(k + 1000)};
      b0.in_dest   = 5'(k);
      #1;
      n_cmp++;
      if (b0.in_ready !== (!b0.out_valid || b0.out_ready) || b0.occupancy > 2'd1) begin
        n_bad++; $display("FAIL skid0_ready cyc=%0d got r=%b occ=%0d required r=%b occ<=1",
          k, b0.in_ready, b0.occupancy, (!b0.out_valid || b0.out_ready));
      end
      step();
    end
    b0.in_valid = 0; b0.out_ready = 1;
    step(); step(); step();
    n_cmp++;
    if (q0.size() != 0) begin
      n_bad++; $display("FAIL skid0_lost got=%0d pending required=0", q0.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skid();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_skid0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
